// File: rtl/spi_mem_fsm_pkg.sv
// Shared definitions for the SPI memory slave transaction controller:
// state encoding and default transaction geometry.
package spi_mem_pkg;

    localparam int ADDR_BITS_DEF = 8;
    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        GET_ADDR     = 4'd1,
        ADDR_SETTLE  = 4'd2,
        GOT_ADDR     = 4'd3,
        READ_MEM     = 4'd4,
        READ_LOAD    = 4'd5,
        READ_SEND    = 4'd6,
        WRITE_GET    = 4'd7,
        WRITE_SETTLE = 4'd8,
        WRITE_STORE  = 4'd9,
        DONE         = 4'd10
    } state_e;

endpackage

// File: rtl/spi_mem_fsm_if.sv
// Signals between the input conditioners and the transaction controller,
// and the strobes the controller hands to the memory-side blocks.
interface spi_mem_fsm_if;

    logic cs;
    logic sclk_pos;
    logic sclk_neg;
    logic rw_bit;
    logic addr_we;
    logic dm_we;
    logic sr_we;
    logic miso_buff;
    logic busy;

    modport master (
        output cs, sclk_pos, sclk_neg, rw_bit,
        input  addr_we, dm_we, sr_we, miso_buff, busy
    );

    modport slave (
        input  cs, sclk_pos, sclk_neg, rw_bit,
        output addr_we, dm_we, sr_we, miso_buff, busy
    );

endinterface

// File: rtl/spi_mem_fsm_bit_counter.sv
// Bit counter shared by the header and data phases; flags the increment
// that lands on the terminal value.
module spi_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = inc_i && (cnt_q == term_i);

endmodule

// File: rtl/spi_mem_fsm.sv
// Transaction controller: one address/R-W header and one data byte per
// chip-select assertion, sequencing latch, memory, shift-load and MISO enable.
module spi_mem_fsm
    import spi_mem_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_W     = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    spi_mem_fsm_if.slave  bus
);

    localparam logic [CNT_W-1:0] ADDR_TERM = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_TERM = CNT_W'(DATA_BITS - 1);

    state_e           state_q, state_d;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_term;
    logic             sclk_neg_unused;

    // Falling edges carry no meaning here; all counting is on rising edges.
    assign sclk_neg_unused = bus.sclk_neg;

    always_comb begin
        state_d  = state_q;
        cnt_inc  = 1'b0;
        cnt_term = DATA_TERM;
        case (state_q)
            IDLE: begin
                if (!bus.cs) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                cnt_inc  = bus.sclk_pos;
                cnt_term = ADDR_TERM;
                if (cnt_tc) state_d = ADDR_SETTLE;
            end
            ADDR_SETTLE:  state_d = GOT_ADDR;
            GOT_ADDR:     state_d = bus.rw_bit ? READ_MEM : WRITE_GET;
            READ_MEM:     state_d = READ_LOAD;
            READ_LOAD:    state_d = READ_SEND;
            READ_SEND: begin
                cnt_inc = bus.sclk_pos;
                if (cnt_tc) state_d = DONE;
            end
            WRITE_GET: begin
                cnt_inc = bus.sclk_pos;
                if (cnt_tc) state_d = WRITE_SETTLE;
            end
            WRITE_SETTLE: state_d = WRITE_STORE;
            WRITE_STORE:  state_d = DONE;
            DONE:         state_d = DONE;
            default:      state_d = IDLE;
        endcase

        // Deselect wins over everything, so an aborted transfer emits no further strobe.
        if (bus.cs) begin
            state_d = IDLE;
            cnt_inc = 1'b0;
        end
    end

    assign cnt_clr = bus.cs || (state_d != state_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    spi_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .term_i  (cnt_term),
        .tc_o    (cnt_tc)
    );

    assign bus.addr_we   = (state_q == GOT_ADDR);
    assign bus.sr_we     = (state_q == READ_LOAD);
    assign bus.dm_we     = (state_q == WRITE_STORE);
    assign bus.miso_buff = (state_q == READ_SEND);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_mem_fsm.sv
// Directed bench for the SPI memory transaction controller.
module tb_spi_mem_fsm;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    spi_mem_fsm_if bus ();

    spi_mem_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int n_addr, n_dm, n_sr, n_miso;

    // Advance one clock and observe the state entered at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        n_addr += int'(bus.addr_we);
        n_dm   += int'(bus.dm_we);
        n_sr   += int'(bus.sr_we);
        n_miso += int'(bus.miso_buff);
    endtask

    task automatic clr_counts();
        n_addr = 0; n_dm = 0; n_sr = 0; n_miso = 0;
    endtask

    task automatic pulse(input logic neg);
        bus.sclk_pos = 1'b1; bus.sclk_neg = neg;
        tick();
        bus.sclk_pos = 1'b0;
        tick();
        bus.sclk_neg = 1'b0;
    endtask

    task automatic send_header(input logic rw, input logic settle_pulse, input string tag);
        bus.rw_bit = rw;
        for (int i = 0; i < 7; i++) pulse(1'b0);
        checks++;
        if (n_addr !== 0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_pre8: addr_we count %0d busy %b, required 0 and 1", tag, n_addr, bus.busy);
        end
        bus.sclk_pos = 1'b1;
        tick();
        bus.sclk_pos = settle_pulse;
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy} !== 5'b00001) begin
            errors++;
            $display("FAIL %s_settle: outputs %b, required 00001", tag,
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy});
        end
        tick();
        bus.sclk_pos = 1'b0;
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_got_addr: strobes %b, required 1000", tag,
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff});
        end
    endtask

    task automatic write_data(input string tag);
        tick();
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy} !== 5'b00001) begin
            errors++;
            $display("FAIL %s_wget: outputs %b, required 00001", tag,
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy});
        end
        for (int i = 0; i < 7; i++) pulse(1'b0);
        checks++;
        if (n_dm !== 0) begin
            errors++;
            $display("FAIL %s_pre8: dm_we count %0d, required 0", tag, n_dm);
        end
        bus.sclk_pos = 1'b1;
        tick();
        bus.sclk_pos = 1'b0;
        checks++;
        if (bus.dm_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_wsettle: dm_we %b, required 0", tag, bus.dm_we);
        end
        tick();
        checks++;
        if (bus.dm_we !== 1'b1) begin
            errors++;
            $display("FAIL %s_wstore: dm_we %b, required 1", tag, bus.dm_we);
        end
        tick();
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy} !== 5'b00001) begin
            errors++;
            $display("FAIL %s_done: outputs %b, required 00001", tag,
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy});
        end
        checks++;
        if (n_addr !== 1 || n_dm !== 1 || n_sr !== 0 || n_miso !== 0) begin
            errors++;
            $display("FAIL %s_counts: addr %0d dm %0d sr %0d miso %0d, required 1 1 0 0",
                     tag, n_addr, n_dm, n_sr, n_miso);
        end
    endtask

    task automatic read_data(input logic load_pulse, input string tag);
        tick();
        checks++;
        if (bus.sr_we !== 1'b0 || bus.miso_buff !== 1'b0) begin
            errors++;
            $display("FAIL %s_rmem: sr_we %b miso %b, required 0 0", tag, bus.sr_we, bus.miso_buff);
        end
        tick();
        bus.sclk_pos = load_pulse;
        checks++;
        if (bus.sr_we !== 1'b1) begin
            errors++;
            $display("FAIL %s_rload: sr_we %b, required 1", tag, bus.sr_we);
        end
        tick();
        bus.sclk_pos = 1'b0;
        checks++;
        if (bus.miso_buff !== 1'b1 || bus.sr_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsend: miso %b sr_we %b, required 1 0", tag, bus.miso_buff, bus.sr_we);
        end
        for (int i = 0; i < 7; i++) pulse(1'b1);
        checks++;
        if (bus.miso_buff !== 1'b1) begin
            errors++;
            $display("FAIL %s_pre8: miso %b, required 1", tag, bus.miso_buff);
        end
        bus.sclk_pos = 1'b1;
        tick();
        bus.sclk_pos = 1'b0;
        checks++;
        if ({bus.miso_buff, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL %s_done: miso/busy %b, required 01", tag, {bus.miso_buff, bus.busy});
        end
        checks++;
        if (n_addr !== 1 || n_dm !== 0 || n_sr !== 1 || n_miso !== 15) begin
            errors++;
            $display("FAIL %s_counts: addr %0d dm %0d sr %0d miso %0d, required 1 0 1 15",
                     tag, n_addr, n_dm, n_sr, n_miso);
        end
    endtask

    task automatic end_txn(input string tag);
        bus.cs = 1'b1;
        tick();
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy} !== 5'b00000) begin
            errors++;
            $display("FAIL %s_idle: outputs %b, required 00000", tag,
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy});
        end
    endtask

    task automatic start_txn();
        bus.cs = 1'b0;
        tick();
        clr_counts();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state: outputs %b, required 00000",
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy});
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        start_txn();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_start: busy %b, required 1", bus.busy);
        end
        for (int i = 0; i < 3; i++) pulse(1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async: outputs %b, required 00000",
                     {bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_buff, bus.busy});
        end
        #1;
        reset_n = 1'b1;
        tick();
        clr_counts();
        send_header(1'b0, 1'b0, "rst_hdr");
        write_data("rst_wr");
        end_txn("rst");
    endtask

    task automatic test_write();
        start_txn();
        send_header(1'b0, 1'b0, "wr_hdr");
        write_data("wr");
        end_txn("wr");
    endtask

    task automatic test_read();
        start_txn();
        send_header(1'b1, 1'b0, "rd_hdr");
        read_data(1'b0, "rd");
        end_txn("rd");
    endtask

    task automatic test_abort();
        start_txn();
        send_header(1'b0, 1'b0, "ab5_hdr");
        tick();
        for (int i = 0; i < 5; i++) pulse(1'b0);
        end_txn("ab5");
        repeat (4) tick();
        checks++;
        if (n_dm !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ab5_nodm: dm_we count %0d busy %b, required 0 0", n_dm, bus.busy);
        end

        start_txn();
        send_header(1'b0, 1'b0, "ab8_hdr");
        tick();
        for (int i = 0; i < 7; i++) pulse(1'b0);
        bus.sclk_pos = 1'b1;
        end_txn("ab8");
        bus.sclk_pos = 1'b0;
        repeat (4) tick();
        checks++;
        if (n_dm !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ab8_nodm: dm_we count %0d busy %b, required 0 0", n_dm, bus.busy);
        end
    endtask

    task automatic test_ignored_edges();
        start_txn();
        send_header(1'b1, 1'b1, "ign_hdr");
        read_data(1'b1, "ign_rd");
        for (int i = 0; i < 4; i++) pulse(1'b1);
        checks++;
        if (bus.busy !== 1'b1 || n_addr !== 1 || n_dm !== 0 || n_sr !== 1 || n_miso !== 15) begin
            errors++;
            $display("FAIL ign_done: busy %b addr %0d dm %0d sr %0d miso %0d, required 1 1 0 1 15",
                     bus.busy, n_addr, n_dm, n_sr, n_miso);
        end
        end_txn("ign");
    endtask

    task automatic test_back_to_back();
        start_txn();
        send_header(1'b0, 1'b0, "b2b_wr_hdr");
        write_data("b2b_wr");
        end_txn("b2b_wr");
        start_txn();
        send_header(1'b1, 1'b0, "b2b_rd_hdr");
        read_data(1'b0, "b2b_rd");
        end_txn("b2b_rd");
    endtask

    initial begin
        bus.cs       = 1'b1;
        bus.sclk_pos = 1'b0;
        bus.sclk_neg = 1'b0;
        bus.rw_bit   = 1'b0;
        clr_counts();
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_ignored_edges();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mem_fsm.md
Name: spi_mem_fsm

Overview:
- Transaction controller for the SPI memory slave.
- Consumes the conditioned chip-select and SCLK edge pulses, plus bit 0 of the shift-register parallel output (the R/W flag).
- Sequences the address latch, data-memory write, shift-register parallel load and MISO tri-state enable for one 8-bit-address / 8-bit-data transaction per CS assertion.
- Sits between the input conditioners and the address latch / datamemory / shiftregister / output buffer.

Parameters:
- ADDR_BITS, 8, header bits per transaction: 7 address bits plus the R/W flag (LSB, 1 = read).
- DATA_BITS, 8, data bits per transaction.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > max(ADDR_BITS, DATA_BITS).

Ports:
- clk  in  1  FPGA clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  conditioned chip select, active low (1 = deselected).
- sclk_pos  in  1  one-clk pulse on SCLK rising edge.
- sclk_neg  in  1  one-clk pulse on SCLK falling edge.
- rw_bit  in  1  shift-register parallel output bit 0.
- addr_we  out  1  address-latch write strobe.
- dm_we  out  1  data-memory write strobe.
- sr_we  out  1  shift-register parallel-load strobe.
- miso_buff  out  1  MISO tri-state enable.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, counter 0, all outputs 0.
- Outputs are Moore, decoded from registered state:
  - addr_we=1 only in GOT_ADDR.
  - sr_we=1 only in READ_LOAD.
  - dm_we=1 only in WRITE_STORE.
  - miso_buff=1 only in READ_SEND.
- Priority rule: cs=1 sampled in any state forces IDLE on the next clk and clears the counter. This overrides every other transition, including terminal-count and strobe transitions. An aborted transaction therefore never emits a further addr_we, sr_we or dm_we.
- IDLE: cs=0 -> GET_ADDR, counter 0.
- GET_ADDR: each sclk_pos increments the counter. The sclk_pos that arrives with counter == ADDR_BITS-1 moves to ADDR_SETTLE and clears the counter.
- ADDR_SETTLE: one clk, no outputs. Covers the one-cycle shift-register parallel-output lag. Then -> GOT_ADDR.
- GOT_ADDR: one clk, addr_we=1, rw_bit sampled. rw_bit=1 -> READ_MEM; rw_bit=0 -> WRITE_GET.
- READ_MEM: one clk, no outputs; covers synchronous memory read latency. -> READ_LOAD.
- READ_LOAD: one clk, sr_we=1. -> READ_SEND.
- READ_SEND: miso_buff=1. Count sclk_pos. The pulse with counter == DATA_BITS-1 -> DONE. sclk_neg is ignored for counting.
- WRITE_GET: count sclk_pos. The pulse with counter == DATA_BITS-1 -> WRITE_SETTLE.
- WRITE_SETTLE: one clk, no outputs. -> WRITE_STORE.
- WRITE_STORE: one clk, dm_we=1. -> DONE.
- DONE: all strobes 0, busy=1. Extra SCLK edges are ignored. cs=1 -> IDLE.
- SCLK edges received in IDLE, the settle states or the strobe states are ignored and not counted.
- sclk_pos and sclk_neg asserted in the same cycle: process sclk_pos only.
- Latencies:
  - 8th header sclk_pos to addr_we: 2 clks.
  - 8th data sclk_pos to dm_we: 2 clks.
  - GOT_ADDR to sr_we: 2 clks.
- Counter: CNT_W-bit unsigned, cleared on every state change, never wraps within a transaction.
- State encoding: 4-bit binary; any illegal code returns to IDLE on the next clk.

Decomposition:
- Package spi_mem_pkg holds the 4-bit state localparams (IDLE, GET_ADDR, ADDR_SETTLE, GOT_ADDR, READ_MEM, READ_LOAD, READ_SEND, WRITE_GET, WRITE_SETTLE, WRITE_STORE, DONE) and the default ADDR_BITS / DATA_BITS constants.
- One sub-module, spi_bit_counter: has clear, increment-enable and terminal-value inputs, and a terminal-count output (counter == terminal-value AND increment). Instantiated once and shared by the header and data phases.

Test Plan:
- Reset: assert reset_n=0 mid-GET_ADDR after 3 sclk_pos -> all outputs 0 immediately, busy=0; after release, cs=0 starts a fresh count from 0.
- Write: cs=0, 8 sclk_pos with rw_bit=0 at GOT_ADDR, then 8 more sclk_pos -> addr_we exactly one clk 2 clks after the 8th pulse; dm_we exactly one clk 2 clks after the 16th pulse; miso_buff never high.
- Read: same header with rw_bit=1 -> addr_we one clk, then sr_we one clk 2 clks later; miso_buff high from READ_SEND entry through the 8th data sclk_pos; state DONE afterwards.
- Abort: cs=1 after 5 data sclk_pos in WRITE_GET -> IDLE next clk, dm_we never asserted. Repeat with cs=1 in the same cycle as the 8th data pulse -> IDLE, no dm_we.
- Ignored edges: sclk_pos during ADDR_SETTLE/READ_LOAD and 4 extra pulses in DONE -> counter unaffected, no strobes, busy stays 1 until cs=1.
- Back-to-back: write to address 0x15 then read from 0x15 with one IDLE clk between -> each transaction produces exactly one addr_we and one dm_we or sr_we.
